instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the CPU fetch stage and the 128-bit-block instruction memory. It returns the 32-bit instruction for the current PC in the same cycle on a hit. On a miss it stalls the fetch stage, fetches the whole 16-byte block from instruction memory over a busywait handshake, installs it, and then serves the hit.

---
 rtl/instruction_cache_pkg.sv | 22 ++
 rtl/instruction_cache_word_select.sv | 12 +
 rtl/instruction_cache.sv | 130 +++++++++++++
 tb/tb_instruction_cache.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the instruction cache (and the data cache that reuses
// the word-select helper): FSM encoding, block geometry, word extraction.
package instruction_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_FETCH = 2'd1,
        UPDATE    = 2'd2
    } icache_state_t;

    localparam int BLOCK_BYTES = 16;
    localparam int WORD_OFF_W  = 2;
    localparam int BYTE_OFF_W  = 2;
    localparam int BLOCK_W     = BLOCK_BYTES * 8;

    // Word n of a block lives in bits [32n+31:32n].
    function automatic logic [31:0] select_word(input logic [BLOCK_W-1:0]  blk,
                                                input logic [WORD_OFF_W-1:0] off);
        return blk[{off, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/instruction_cache_word_select.sv
// Combinational 128-to-32 mux picking the addressed word out of a cache line.
module icache_word_select
    import instruction_cache_pkg::*;
(
    input  logic [BLOCK_W-1:0]    i_block,
    input  logic [WORD_OFF_W-1:0] i_word_off,
    output logic [31:0]           o_word
);

    assign o_word = select_word(i_block, i_word_off);

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with a busywait fill from 128-bit memory.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 32 - 4 - INDEX_W
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               READ,
    input  logic [31:0]        PC,
    output logic [31:0]        INSTRUCTION,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic [27:0]        MEM_ADDRESS,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]        HIT_COUNT,
    output logic [31:0]        MISS_COUNT
`endif
);

    localparam int SETS = 1 << INDEX_W;

    logic               r_valid [SETS];
    logic [TAG_W-1:0]   r_tag   [SETS];
    logic [BLOCK_W-1:0] r_data  [SETS];

    icache_state_t      r_state;
    logic [BLOCK_W-1:0] r_block;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_miss;
    logic [BLOCK_W-1:0] w_line;
    logic               w_unused_pc;

    assign w_index     = PC[4 +: INDEX_W];
    assign w_tag       = PC[31 -: TAG_W];
    assign w_unused_pc = ^PC[BYTE_OFF_W-1:0];

    // Tag lookup is combinational so a hit costs no stall cycle.
    assign w_hit  = READ & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_miss = (r_state == IDLE) & READ & ~w_hit;
    assign w_line = r_data[w_index];

    assign MEM_READ    = (r_state == MEM_FETCH);
    assign BUSYWAIT    = (r_state == IDLE) ? (READ & ~w_hit) : 1'b1;
    assign MEM_ADDRESS = PC[31:4];

    icache_word_select u_word_select (
        .i_block    (w_line),
        .i_word_off (PC[3:2]),
        .o_word     (INSTRUCTION)
    );

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge CLOCK) begin
                if (RESET) begin
                    r_valid[gi] <= 1'b0;
                end else if (r_state == UPDATE && w_index == INDEX_W'(gi)) begin
                    r_valid[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge CLOCK) begin
        if (!RESET && r_state == UPDATE) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= r_block;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_block <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_state <= MEM_FETCH;
                    end
                end
                MEM_FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        r_block <= MEM_READDATA;
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (r_state == IDLE && w_hit && r_hit_count != 32'hFFFF_FFFF) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && r_miss_count != 32'hFFFF_FFFF) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign HIT_COUNT  = r_hit_count;
    assign MISS_COUNT = r_miss_count;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: fixed-latency memory, per-cycle model compare,
// and directed fetch sequences with literal expectations.
module tb_instruction_cache;

    localparam int L = 5;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic         READ  = 1'b0;
    logic [31:0]  PC    = 32'h0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;
`endif

    int tests = 0;
    int fails = 0;

    instruction_cache dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .READ         (READ),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] mem_word(input logic [27:0] a, input logic [1:0] n);
        if (a == 28'h0) begin
            case (n)
                2'd0:    return 32'h8F10_8093;
                2'd1:    return 32'h0050_0113;
                2'd2:    return 32'h00A0_0193;
                default: return 32'h0000_F613;
            endcase
        end
        return {a[19:0], 10'h0, n} + 32'h0000_0013;
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] a);
        logic [127:0] b;
        for (int n = 0; n < 4; n++) b[32*n +: 32] = mem_word(a, 2'(n));
        return b;
    endfunction

    // Memory: busy for L cycles after MEM_READ rises, data valid on the next.
    int mem_cnt = 0;
    always @(posedge CLOCK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
    assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < L);
    assign MEM_READDATA = MEM_BUSYWAIT ? {4{32'hDEAD_BEEF}} : mem_block(MEM_ADDRESS);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: resident tag per set plus a countdown of remaining stall cycles.
    bit          armed = 1'b0;
    int          stall = 0;
    bit          mv [8];
    logic [24:0] mt [8];
    logic [31:0] prev_pc = 32'h0;
    bit          prev_busy = 1'b0;
    logic [31:0] m_hits = 32'h0;
    logic [31:0] m_miss = 32'h0;

    always @(negedge CLOCK) begin
        logic [2:0] idx;
        logic       hit;
        logic       exp_busy;
        idx = PC[6:4];
        hit = READ && mv[idx] && (mt[idx] == PC[31:7]);
        exp_busy = (stall > 0) ? 1'b1 : (READ && !hit);
        if (armed) begin
            chk("busywait", {31'h0, BUSYWAIT}, {31'h0, exp_busy});
            chk("mem_read", {31'h0, MEM_READ}, {31'h0, stall > 1});
            chk("mem_address", {4'h0, MEM_ADDRESS}, {4'h0, PC[31:4]});
            if (READ && !exp_busy)
                chk("instruction", INSTRUCTION, mem_word(PC[31:4], PC[3:2]));
            if (prev_busy)
                chk("pc_stable_during_stall", PC, prev_pc);
            prev_busy = BUSYWAIT;
            prev_pc   = PC;
        end
        if (RESET) begin
            for (int s = 0; s < 8; s++) mv[s] = 1'b0;
            stall  = 0;
            armed  = 1'b1;
            m_hits = 32'h0;
            m_miss = 32'h0;
        end else if (armed) begin
            if (stall > 0) begin
                stall--;
                if (stall == 0) begin
                    mv[idx] = 1'b1;
                    mt[idx] = PC[31:7];
                end
            end else if (READ && !hit) begin
                stall = L + 2;
                if (m_miss != 32'hFFFF_FFFF) m_miss++;
            end else if (READ && hit) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits++;
            end
        end
    end

    task automatic do_read(input logic [31:0] pc, output int stalls, output int mreads,
                           output logic [31:0] instr);
        bit done;
        @(posedge CLOCK); #1;
        PC = pc;
        READ = 1'b1;
        stalls = 0;
        mreads = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge CLOCK);
            if (BUSYWAIT) begin
                stalls++;
                if (MEM_READ) mreads++;
            end else begin
                done = 1'b1;
            end
        end
        chk("read_completes", {31'h0, done}, 32'h1);
        instr = INSTRUCTION;
        $display("[TB] read pc=0x%08h stalls=%0d mem_read_cycles=%0d instr=0x%08h",
                 pc, stalls, mreads, instr);
    endtask

    initial begin
        int          st, mr, sum_st, sum_mr;
        logic [31:0] ins;
        bit          seen;

        repeat (3) @(posedge CLOCK);
        #1 RESET = 1'b0;
        @(negedge CLOCK);
        chk("reset_busywait", {31'h0, BUSYWAIT}, 32'h0);
        chk("reset_mem_read", {31'h0, MEM_READ}, 32'h0);

        // Cold miss: request cycle + L+2 stall (L+1 fetch cycles, one install).
        do_read(32'h0000_0000, st, mr, ins);
        chk("cold_penalty", st - 1, L + 2);
        chk("cold_mem_read_cycles", mr, L + 1);
        chk("cold_word0", ins, 32'h8F10_8093);

        do_read(32'h0000_0004, st, mr, ins);
        chk("word1_stall", st, 0);
        chk("word1", ins, 32'h0050_0113);
        do_read(32'h0000_0008, st, mr, ins);
        chk("word2_stall", st, 0);
        do_read(32'h0000_000C, st, mr, ins);
        chk("word3_stall", st, 0);
        chk("word3", ins, 32'h0000_F613);

        // Conflict on index 0, then the original line must be gone.
        do_read(32'h0000_0080, st, mr, ins);
        chk("conflict_refill", mr, L + 1);
        do_read(32'h0000_0000, st, mr, ins);
        chk("evicted_refill", mr, L + 1);

        for (int s = 0; s < 8; s++) do_read(32'(s * 16), st, mr, ins);
        sum_st = 0;
        sum_mr = 0;
        for (int s = 0; s < 8; s++) begin
            do_read(32'(s * 16 + 4), st, mr, ins);
            sum_st += st;
            sum_mr += mr;
        end
        chk("all_sets_hit_stalls", sum_st, 0);
        chk("all_sets_hit_mem_reads", sum_mr, 0);

`ifdef ICACHE_PERF_CNT_EN
        @(negedge CLOCK);
        chk("hit_count", HIT_COUNT, m_hits);
        chk("miss_count", MISS_COUNT, m_miss);
`endif

        // Reset mid-fetch aborts the fill and invalidates everything.
        @(posedge CLOCK); #1;
        PC = 32'h0000_0200;
        READ = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CLOCK);
            if (MEM_READ) seen = 1'b1;
        end
        chk("fetch_started", {31'h0, seen}, 32'h1);
        @(posedge CLOCK); #1 RESET = 1'b1;
        @(posedge CLOCK); #1 RESET = 1'b0;
        @(negedge CLOCK);
        chk("abort_mem_read", {31'h0, MEM_READ}, 32'h0);
        chk("abort_busywait", {31'h0, BUSYWAIT}, 32'h1);
        do_read(32'h0000_0200, st, mr, ins);
        chk("abort_refetch", mr, L + 1);
        do_read(32'h0000_0010, st, mr, ins);
        chk("valid_cleared", mr, L + 1);

`ifdef ICACHE_PERF_CNT_EN
        @(negedge CLOCK);
        chk("hit_count_after_reset", HIT_COUNT, m_hits);
        chk("miss_count_after_reset", MISS_COUNT, m_miss);
        force dut.r_hit_count = 32'hFFFF_FFFE;
        @(posedge CLOCK); #1 release dut.r_hit_count;
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("hit_count_saturates", HIT_COUNT, 32'hFFFF_FFFF);
`endif

        @(posedge CLOCK); #1 READ = 1'b0;
        repeat (2) @(posedge CLOCK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
